frame_reader: RTL and testbench
===============================

FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter Width, default 5, image columns (X extent); 1..512.
REQ-002 Parameter Height, default 10, image rows (Y extent); 1..256.
REQ-003 Parameter ColorBits, default 3, bits per pixel.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to stream one full frame.
REQ-007 XRead  output  9  column address presented to image memory read port.
REQ-008 YRead  output  8  row address presented to image memory read port.
REQ-009 ReadValue  input  ColorBits  pixel returned by memory; valid in the cycle after the address was sampled by memory (1-cycle registered read).
REQ-010 pixel_data  output  ColorBits  streamed pixel.
REQ-011 pixel_valid  output  1  pixel_data holds a pixel.
REQ-012 pixel_ready  input  1  downstream accepts; transfer = pixel_valid & pixel_ready at rising edge.
REQ-013 pixel_last  output  1  high with the final pixel (X=Width-1, Y=Height-1) of a frame.
REQ-014 busy  output  1  high from the cycle after an accepted start until the cycle after the last transfer.
REQ-015 done  output  1  one-cycle pulse in the cycle after the pixel_last transfer.

Function
REQ-016 FSM states IDLE, STREAM, DRAIN; IDLE->STREAM on start; STREAM->DRAIN when the last address is issued; DRAIN->IDLE on the pixel_last transfer.
REQ-017 Scan order is raster: X increments fastest 0..Width-1, then X wraps to 0 and Y increments; Y runs 0..Height-1.
REQ-018 XRead/YRead are registered and advance only in a cycle where a read is issued.
REQ-019 Returned pixels enter a 2-entry output FIFO; pixel_data/pixel_valid are driven from the FIFO head.
REQ-020 A read is issued in a cycle only if (FIFO occupancy + reads in flight - pop this cycle) < 2; the FIFO never overflows and no returned pixel is dropped.
REQ-021 With pixel_ready held high, sustained throughput is one pixel per clock after the initial latency.
REQ-022 First pixel_valid is asserted no later than 3 cycles after the start cycle.
REQ-023 pixel_data and pixel_last remain stable while pixel_valid=1 and pixel_ready=0.
REQ-024 Frame emits exactly Width*Height transfers in raster order; pixel_last is high on the final one only.
REQ-025 start while busy=1 is ignored; start in the same cycle as done is accepted and begins a new frame.
REQ-026 pixel_valid is never asserted in IDLE; pixel_ready in IDLE has no effect.
REQ-027 Width=1 and/or Height=1 are legal; counters wrap correctly and pixel_last marks the sole final pixel.

Reset
REQ-028 On rst_n low, immediately and regardless of clock: state IDLE, XRead=0, YRead=0, FIFO and in-flight count empty, pixel_valid=0, pixel_last=0, pixel_data=0, busy=0, done=0.
REQ-029 Reset mid-frame abandons the frame; no pixels of it are emitted after rst_n returns high; a new start is required.

Verification
REQ-030 Memory model preloaded Image[x][y]=(x+y)%8, defaults, pixel_ready=1, pulse start -> 50 transfers at one per cycle, sequence 0,1,2,3,4,1,2,...,ends with 5 (x=4,y=9), pixel_last only on 50th, done one cycle later, busy then 0.
REQ-031 Same frame, pixel_ready toggles 1,0 every cycle -> identical 50-value sequence, no duplicates or losses, data stable during stalls.
REQ-032 pixel_ready=0 for 20 cycles after start -> at most 2 reads outstanding/buffered, XRead/YRead stop advancing, stream resumes correctly when ready=1.
REQ-033 start pulsed again at transfer 10 -> ignored; exactly 50 transfers total; start in the done cycle -> second frame of 50 follows.
REQ-034 rst_n low at transfer 25 -> all outputs at reset values that cycle; after release, no pixel_valid until new start; next frame begins at (0,0).
REQ-035 Width=1, Height=1 -> single transfer with pixel_last=1, done pulse, return to IDLE.

Source files
------------

// File: rtl/frame_reader_if.sv
// Memory-read and pixel-stream signals of frame_reader, bundled for port use.
// master = the frame reader; slave = image memory plus downstream consumer.
interface frame_reader_if #(
   parameter int unsigned ColorBits = 3
);
   logic                 start;
   logic [8:0]           XRead;
   logic [7:0]           YRead;
   logic [ColorBits-1:0] ReadValue;
   logic [ColorBits-1:0] pixel_data;
   logic                 pixel_valid;
   logic                 pixel_ready;
   logic                 pixel_last;
   logic                 busy;
   logic                 done;

   modport master (
      input  start, ReadValue, pixel_ready,
      output XRead, YRead, pixel_data, pixel_valid, pixel_last, busy, done
   );

   modport slave (
      output start, ReadValue, pixel_ready,
      input  XRead, YRead, pixel_data, pixel_valid, pixel_last, busy, done
   );
endinterface

// File: rtl/frame_reader.sv
// Streams one Width x Height frame in raster order from a 1-cycle-latency image memory
// through a 2-entry output FIFO with valid/ready backpressure.
module frame_reader #(
   parameter int unsigned Width     = 5,
   parameter int unsigned Height    = 10,
   parameter int unsigned ColorBits = 3
) (
   input logic            clk,
   input logic            rst_n,
   frame_reader_if.master bus
);

   localparam logic [8:0] XMax = 9'(Width - 1);
   localparam logic [7:0] YMax = 8'(Height - 1);

   typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

   state_e state_q, state_d;

   logic [8:0]                x_q, x_d;
   logic [7:0]                y_q, y_d;
   logic                      inflight_q, inflight_d;
   logic                      inflight_last_q, inflight_last_d;
   logic [1:0][ColorBits-1:0] fifo_data_q, fifo_data_d;
   logic [1:0]                fifo_last_q, fifo_last_d;
   logic                      rd_ptr_q, rd_ptr_d;
   logic                      wr_ptr_q, wr_ptr_d;
   logic [1:0]                cnt_q, cnt_d;
   logic                      done_q, done_d;

   logic       issue;
   logic       push;
   logic       pop;
   logic       last_addr;
   logic       head_valid;
   logic       head_last;
   logic [2:0] occ;

   assign head_valid = (cnt_q != 2'd0);
   assign head_last  = fifo_last_q[rd_ptr_q];
   assign pop        = head_valid & bus.pixel_ready;
   assign push       = inflight_q;
   assign last_addr  = (x_q == XMax) && (y_q == YMax);
   // Buffered plus in-flight pixels, net of this cycle's pop; a new read must still fit.
   assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.start) state_d = StStream;
         StStream: if (issue && last_addr) state_d = StDrain;
         StDrain:  if (pop && head_last) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.busy = (state_q != StIdle);
      issue    = (state_q == StStream) && (occ < 3'd2);
   end

   // Address counters, in-flight tracking and FIFO next state
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (issue) begin
         if (x_q == XMax) begin
            x_d = '0;
            y_d = (y_q == YMax) ? 8'd0 : y_q + 8'd1;
         end else begin
            x_d = x_q + 9'd1;
         end
      end

      inflight_d      = issue;
      inflight_last_d = issue & last_addr;

      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      wr_ptr_d    = wr_ptr_q;
      if (push) begin
         fifo_data_d[wr_ptr_q] = bus.ReadValue;
         fifo_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d              = ~wr_ptr_q;
      end
      rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      done_d   = pop & head_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q             <= '0;
         y_q             <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q     <= '0;
         fifo_last_q     <= '0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         cnt_q           <= '0;
         done_q          <= 1'b0;
      end else begin
         x_q             <= x_d;
         y_q             <= y_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         fifo_data_q     <= fifo_data_d;
         fifo_last_q     <= fifo_last_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         cnt_q           <= cnt_d;
         done_q          <= done_d;
      end
   end

   assign bus.XRead       = x_q;
   assign bus.YRead       = y_q;
   assign bus.pixel_valid = head_valid;
   assign bus.pixel_data  = head_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign bus.pixel_last  = head_valid & head_last;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a queue-based frame model checked every cycle, plus directed
// scenarios (stalls, ignored/back-to-back start, mid-frame reset, 1x1 frame).
module tb_frame_reader;

   localparam int unsigned W = 5;
   localparam int unsigned H = 10;

   typedef struct {
      int data;
      bit last;
   } pix_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   pix_t q[$];
   bit   exp_busy;
   bit   exp_done;
   bit   stall_prev;
   int   prev_data;
   bit   prev_last;
   bit   accept;
   int   xfer_cnt;
   int   start_cyc;
   int   first_valid_cyc;
   int   first_xfer_cyc;
   int   last_xfer_cyc;
   int   rec[64];
   int   lit[6] = '{0, 1, 2, 3, 4, 1};

   frame_reader_if #(.ColorBits(3)) bus  ();
   frame_reader_if #(.ColorBits(3)) bus1 ();

   frame_reader #(.Width(W), .Height(H), .ColorBits(3)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   frame_reader #(.Width(1), .Height(1), .ColorBits(3)) dut1 (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Image memories with a registered read port
   always @(posedge clk) begin
      bus.ReadValue  <= 3'((int'(bus.XRead) + int'(bus.YRead)) % 8);
      bus1.ReadValue <= 3'((int'(bus1.XRead) + int'(bus1.YRead) + 5) % 8);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic run_frame(input bit toggle, input int budget);
      int n = 0;
      while (!bus.done && n < budget) begin
         if (toggle) bus.pixel_ready = ~bus.pixel_ready;
         step();
         n++;
      end
      chk("done_seen", int'(bus.done), 1);
      bus.pixel_ready = 1'b1;
   endtask

   task automatic wait_xfers(input int target);
      int n = 0;
      while (xfer_cnt < target && n < 200) begin
         step();
         n++;
      end
      chk("xfers_reached", int'(xfer_cnt >= target), 1);
   endtask

   // Model of the main DUT: expected pixel queue, busy and done, checked every cycle
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_valid", int'(bus.pixel_valid), 0);
            chk("rst_last", int'(bus.pixel_last), 0);
            chk("rst_data", int'(bus.pixel_data), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_xread", int'(bus.XRead), 0);
            chk("rst_yread", int'(bus.YRead), 0);
            q.delete();
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            stall_prev = 1'b0;
         end else begin
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("done", int'(bus.done), int'(exp_done));
            if (bus.pixel_valid) begin
               if (q.size() == 0) begin
                  chk("valid_unexpected", 1, 0);
               end else begin
                  chk("data", int'(bus.pixel_data), q[0].data);
                  chk("last", int'(bus.pixel_last), int'(q[0].last));
               end
               if (stall_prev) begin
                  chk("stall_data", int'(bus.pixel_data), prev_data);
                  chk("stall_last", int'(bus.pixel_last), int'(prev_last));
               end
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end else if (stall_prev) begin
               chk("stall_valid", 0, 1);
            end

            accept   = bus.start && !exp_busy;
            exp_done = 1'b0;
            if (bus.pixel_valid && bus.pixel_ready && q.size() > 0) begin
               if (xfer_cnt < 64) rec[xfer_cnt] = int'(bus.pixel_data);
               if (xfer_cnt == 0) first_xfer_cyc = cyc;
               last_xfer_cyc = cyc;
               xfer_cnt++;
               if (q[0].last) begin
                  exp_done = 1'b1;
                  exp_busy = 1'b0;
               end
               void'(q.pop_front());
            end
            stall_prev = bus.pixel_valid && !bus.pixel_ready;
            prev_data  = int'(bus.pixel_data);
            prev_last  = bus.pixel_last;

            if (accept) begin
               exp_busy        = 1'b1;
               xfer_cnt        = 0;
               start_cyc       = cyc;
               first_valid_cyc = -1;
               for (int yy = 0; yy < int'(H); yy++) begin
                  for (int xx = 0; xx < int'(W); xx++) begin
                     q.push_back('{data: (xx + yy) % 8,
                                   last: (xx == int'(W) - 1) && (yy == int'(H) - 1)});
                  end
               end
            end
         end
      end
   end

   initial begin
      int n;
      bus.start        = 1'b0;
      bus.pixel_ready  = 1'b1;
      bus1.start       = 1'b0;
      bus1.pixel_ready = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Full frame, ready held high
      pulse_start();
      run_frame(1'b0, 200);
      chk("t1_count", xfer_cnt, 50);
      for (int i = 0; i < 6; i++) chk("t1_seq", rec[i], lit[i]);
      chk("t1_final", rec[49], 5);
      chk("t1_latency_le3", int'(first_valid_cyc - start_cyc <= 3), 1);
      chk("t1_span", last_xfer_cyc - first_xfer_cyc, 49);
      chk("t1_busy_in_done", int'(bus.busy), 0);
      step();

      // ready toggling every cycle
      pulse_start();
      run_frame(1'b1, 300);
      chk("t2_count", xfer_cnt, 50);
      chk("t2_final", rec[49], 5);
      step();

      // ready low for 20 cycles after start
      bus.pixel_ready = 1'b0;
      pulse_start();
      repeat (10) step();
      chk("t3_xread_a", int'(bus.XRead), 2);
      chk("t3_yread_a", int'(bus.YRead), 0);
      chk("t3_valid", int'(bus.pixel_valid), 1);
      repeat (10) step();
      chk("t3_xread_b", int'(bus.XRead), 2);
      chk("t3_yread_b", int'(bus.YRead), 0);
      bus.pixel_ready = 1'b1;
      run_frame(1'b0, 200);
      chk("t3_count", xfer_cnt, 50);
      step();

      // start while busy ignored; start in the done cycle accepted
      pulse_start();
      wait_xfers(10);
      pulse_start();
      run_frame(1'b0, 200);
      chk("t4_count_a", xfer_cnt, 50);
      pulse_start();
      chk("t4_busy_b2b", int'(bus.busy), 1);
      run_frame(1'b0, 200);
      chk("t4_count_b", xfer_cnt, 50);
      step();

      // reset mid-frame
      pulse_start();
      wait_xfers(25);
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", int'(bus.pixel_valid), 0);
      chk("t5_async_busy", int'(bus.busy), 0);
      chk("t5_async_xread", int'(bus.XRead), 0);
      step();
      step();
      rst_n = 1'b1;
      repeat (5) begin
         step();
         chk("t5_idle_valid", int'(bus.pixel_valid), 0);
      end
      pulse_start();
      run_frame(1'b0, 200);
      chk("t5_count", xfer_cnt, 50);
      chk("t5_first", rec[0], 0);
      step();

      // 1x1 frame
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      chk("w1_busy", int'(bus1.busy), 1);
      n = 0;
      while (!bus1.pixel_valid && n < 5) begin
         step();
         n++;
      end
      chk("w1_valid", int'(bus1.pixel_valid), 1);
      chk("w1_latency", n, 2);
      chk("w1_last", int'(bus1.pixel_last), 1);
      chk("w1_data", int'(bus1.pixel_data), 5);
      step();
      chk("w1_done", int'(bus1.done), 1);
      chk("w1_busy_end", int'(bus1.busy), 0);
      chk("w1_valid_end", int'(bus1.pixel_valid), 0);
      step();
      chk("w1_done_pulse", int'(bus1.done), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
